alu_mc: RTL and testbench

//  Multi-cycle, handshaked successor to the combinational ALU; same 3-bit opcode map.

---
 rtl/alu_mc_pkg.sv | 20 ++
 rtl/alu_mc_if.sv | 29 ++
 rtl/alu_mc_iter_core.sv | 75 +++++++
 rtl/alu_mc.sv | 132 +++++++++++++
 tb/tb_alu_mc.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcode map and FSM encoding for the multi-cycle ALU.
// Imported by the ALU top and its testbench.
package alu_mc_pkg;

    localparam logic [2:0] OC_ADD = 3'b000;
    localparam logic [2:0] OC_SUB = 3'b001;
    localparam logic [2:0] OC_MUL = 3'b010;
    localparam logic [2:0] OC_DIV = 3'b011;
    localparam logic [2:0] OC_NOT = 3'b100;
    localparam logic [2:0] OC_XOR = 3'b101;
    localparam logic [2:0] OC_OR  = 3'b110;
    localparam logic [2:0] OC_AND = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between the decode stage, the ALU and write-back.
// The slave modport is the ALU side; master is the producer/consumer side.
interface alu_mc_if #(parameter int DATA_WIDTH = 16);

    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            oc;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] f;
    logic [DATA_WIDTH-1:0] f_hi;
    logic                  flag_z;
    logic                  flag_c;
    logic                  flag_v;
    logic                  flag_dz;

    modport slave (
        input  in_valid, oc, a, b, out_ready,
        output in_ready, out_valid, f, f_hi, flag_z, flag_c, flag_v, flag_dz
    );

    modport master (
        output in_valid, oc, a, b, out_ready,
        input  in_ready, out_valid, f, f_hi, flag_z, flag_c, flag_v, flag_dz
    );

endinterface

// File: rtl/alu_mc_iter_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Results are presented combinationally in the final iteration cycle (done=1).
module alu_iter_core #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_mul,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] res_lo,
    output logic [DATA_WIDTH-1:0] res_hi
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic          busy;
    logic          mul_q;
    logic [CW-1:0] cnt;
    // hi: product high half / partial remainder; lo: multiplier bits / quotient bits
    logic [W-1:0]  hi, lo, d;
    logic [W-1:0]  hi_nxt, lo_nxt;
    logic [W:0]    sum, rem_sh, rem_sub;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hi_nxt  = hi;
        lo_nxt  = lo;
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
        rem_sh  = {hi, lo[W-1]};
        rem_sub = rem_sh - {1'b0, d};
        if (mul_q) begin
            hi_nxt = sum[W:1];
            lo_nxt = {sum[0], lo[W-1:1]};
        end else if (rem_sh >= {1'b0, d}) begin
            hi_nxt = rem_sub[W-1:0];
            lo_nxt = {lo[W-2:0], 1'b1};
        end else begin
            hi_nxt = rem_sh[W-1:0];
            lo_nxt = {lo[W-2:0], 1'b0};
        end
    end

    assign done   = busy && (cnt == CW'(W - 1));
    assign res_lo = lo_nxt;
    assign res_hi = hi_nxt;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            mul_q <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            d     <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            mul_q <= is_mul;
            cnt   <= '0;
            hi    <= '0;
            lo    <= a;
            d     <= b;
        end else if (busy) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + CW'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU: FSM, handshake, single-cycle ops and registered result/flags.
// MUL and DIV (b!=0) are delegated to alu_iter_core.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_mc_if.slave     bus
);

    localparam int W = DATA_WIDTH;

    state_t       state, state_nxt;
    logic         accept, iter_op, core_done;
    logic [2:0]   op_q;
    logic [W-1:0] core_lo, core_hi;

    logic [W-1:0] f_q, f_hi_q;
    logic         z_q, c_q, v_q, dz_q;

    logic [W:0]   add_w, sub_w;
    logic [W-1:0] f_1, f_hi_1;
    logic         c_1, v_1, dz_1;

    assign accept  = bus.in_valid && (state == ST_IDLE);
    assign iter_op = (bus.oc == OC_MUL) || ((bus.oc == OC_DIV) && (bus.b != '0));

    alu_iter_core #(.DATA_WIDTH(W)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && iter_op),
        .is_mul (bus.oc == OC_MUL),
        .a      (bus.a),
        .b      (bus.b),
        .done   (core_done),
        .res_lo (core_lo),
        .res_hi (core_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)        state_nxt = iter_op ? ST_BUSY : ST_DONE;
            ST_BUSY: if (core_done)     state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
    end

    // Single-cycle ops; a DIV reaching here always has b==0.
    always_comb begin
        add_w  = {1'b0, bus.a} + {1'b0, bus.b};
        sub_w  = {1'b0, bus.a} - {1'b0, bus.b};
        f_1    = '0;
        f_hi_1 = '0;
        c_1    = 1'b0;
        v_1    = 1'b0;
        dz_1   = 1'b0;
        case (bus.oc)
            OC_ADD: begin
                f_1 = add_w[W-1:0];
                c_1 = add_w[W];
                v_1 = (bus.a[W-1] == bus.b[W-1]) && (add_w[W-1] != bus.a[W-1]);
            end
            OC_SUB: begin
                f_1 = sub_w[W-1:0];
                c_1 = sub_w[W];
                v_1 = (bus.a[W-1] != bus.b[W-1]) && (sub_w[W-1] != bus.a[W-1]);
            end
            OC_DIV: begin
                f_1    = '1;
                f_hi_1 = bus.a;
                dz_1   = 1'b1;
            end
            OC_NOT:  f_1 = ~bus.a;
            OC_XOR:  f_1 = bus.a ^ bus.b;
            OC_OR:   f_1 = bus.a | bus.b;
            OC_AND:  f_1 = bus.a & bus.b;
            default: f_1 = '0;
        endcase
    end

    // NOTE: the result registers are reset explicitly so outputs read 0 before the first op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OC_ADD;
            f_q    <= '0;
            f_hi_q <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            dz_q   <= 1'b0;
        end else if (accept) begin
            op_q <= bus.oc;
            if (!iter_op) begin
                f_q    <= f_1;
                f_hi_q <= f_hi_1;
                z_q    <= (f_1 == '0);
                c_q    <= c_1;
                v_q    <= v_1;
                dz_q   <= dz_1;
            end
        end else if (core_done) begin
            f_q    <= core_lo;
            f_hi_q <= core_hi;
            z_q    <= (core_lo == '0);
            c_q    <= (op_q == OC_MUL) && (core_hi != '0);
            v_q    <= 1'b0;
            dz_q   <= 1'b0;
        end
    end

    assign bus.f       = f_q;
    assign bus.f_hi    = f_hi_q;
    assign bus.flag_z  = z_q;
    assign bus.flag_c  = c_q;
    assign bus.flag_v  = v_q;
    assign bus.flag_dz = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed vector bench for alu_mc at DATA_WIDTH=16: opcode table plus
// backpressure and mid-operation reset sequences.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.DATA_WIDTH(W)) bus ();

    alu_mc #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]   oc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] f;
        logic [W-1:0] f_hi;
        logic [3:0]   flags;  // {z, c, v, dz}
        int           lat;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_dz};
    endfunction

    // Presents one bundle for one cycle, then scrambles the inputs and waits for out_valid.
    task automatic run_op(input logic [2:0] oc, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        @(negedge clk);
        check("in_ready_before_op", 64'(bus.in_ready), 64'd1);
        bus.oc       = oc;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.oc       = 3'($urandom);
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_after_take", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held_f, held_hi;

        vecs[0]  = '{OC_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1100, 1};
        vecs[1]  = '{OC_SUB, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0100, 1};
        vecs[2]  = '{OC_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0010, 1};
        vecs[3]  = '{OC_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0010, 1};
        vecs[4]  = '{OC_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0100, 17};
        vecs[5]  = '{OC_MUL, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 4'b1000, 17};
        vecs[6]  = '{OC_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0100, 17};
        vecs[7]  = '{OC_DIV, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 4'b0000, 17};
        vecs[8]  = '{OC_DIV, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 4'b0001, 1};
        vecs[9]  = '{OC_DIV, 16'h0003, 16'h0005, 16'h0000, 16'h0003, 4'b1000, 17};
        vecs[10] = '{OC_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b0000, 17};
        vecs[11] = '{OC_NOT, 16'h00FF, 16'h1234, 16'hFF00, 16'h0000, 4'b0000, 1};
        vecs[12] = '{OC_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0, 16'h0000, 4'b0000, 1};
        vecs[13] = '{OC_OR,  16'h1200, 16'h0034, 16'h1234, 16'h0000, 4'b0000, 1};
        vecs[14] = '{OC_AND, 16'hF0F0, 16'h0F0F, 16'h0000, 16'h0000, 4'b1000, 1};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.oc        = OC_ADD;
        bus.a         = '0;
        bus.b         = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_f",         64'(bus.f),         64'd0);
        check("rst_f_hi",      64'(bus.f_hi),      64'd0);
        check("rst_flags",     64'(flags_now()),   64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].oc, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), 64'(lat),          64'(vecs[i].lat));
            check($sformatf("v%0d_f", i),       64'(bus.f),        64'(vecs[i].f));
            check($sformatf("v%0d_f_hi", i),    64'(bus.f_hi),     64'(vecs[i].f_hi));
            check($sformatf("v%0d_flags", i),   64'(flags_now()),  64'(vecs[i].flags));
            finish_op();
            check($sformatf("v%0d_f_kept", i),  64'(bus.f),        64'(vecs[i].f));
        end

        // Backpressure: result held for 5 cycles while new bundles are offered and dropped.
        run_op(OC_MUL, 16'h00FF, 16'h0003, lat);
        check("bp_latency", 64'(lat), 64'd17);
        held_f  = bus.f;
        held_hi = bus.f_hi;
        check("bp_f", 64'(held_f), 64'h02FD);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.oc       = OC_ADD;
            bus.a        = W'(k + 1);
            bus.b        = 16'h0001;
            @(negedge clk);
            check($sformatf("bp%0d_f", k),         64'(bus.f),         64'(held_f));
            check($sformatf("bp%0d_f_hi", k),      64'(bus.f_hi),      64'(held_hi));
            check($sformatf("bp%0d_out_valid", k), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp%0d_in_ready", k),  64'(bus.in_ready),  64'd0);
        end
        bus.in_valid = 1'b0;
        finish_op();
        @(negedge clk);
        check("bp_no_queued_op", 64'(bus.out_valid), 64'd0);
        check("bp_f_after",      64'(bus.f),         64'h02FD);

        // Reset three cycles into a MUL aborts it immediately.
        @(negedge clk);
        bus.oc       = OC_MUL;
        bus.a        = 16'h1234;
        bus.b        = 16'h5678;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("postrst_no_result", 64'(bus.out_valid), 64'd0);
        run_op(OC_ADD, 16'h0002, 16'h0003, lat);
        check("postrst_latency", 64'(lat),   64'd1);
        check("postrst_f",       64'(bus.f), 64'd5);
        finish_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
